fp_min_reduce: RTL
==================

FP_MIN_REDUCE -- requirements
Module: fp_min_reduce

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, total float width.
REQ-002 SHALL have parameter EXPO_WIDTH, default 8, exponent field width.
REQ-003 SHALL have parameter MANT_WIDTH, default 23, mantissa field width; DATA_WIDTH = 1+EXPO_WIDTH+MANT_WIDTH.
REQ-004 SHALL have parameter IDX_WIDTH, default 16, element index/count width.
REQ-005 SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port in_data_i  input  DATA_WIDTH  stream element {sign, expo, mant}.
REQ-008 SHALL have port in_valid_i  input  1  element valid.
REQ-009 SHALL have port in_last_i  input  1  element closes current frame.
REQ-010 SHALL have port in_ready_o  output  1  block accepts element.
REQ-011 SHALL have port out_min_o  output  DATA_WIDTH  frame minimum.
REQ-012 SHALL have port out_idx_o  output  IDX_WIDTH  frame position of minimum, 0-based.
REQ-013 SHALL have port out_count_o  output  IDX_WIDTH  elements in frame.
REQ-014 SHALL have port out_valid_o  output  1  result valid.
REQ-015 SHALL have port out_ready_i  input  1  result consumer ready.

Function
REQ-016 SHALL transfer an input beat when in_valid_i & in_ready_o, an output beat when out_valid_o & out_ready_i.
REQ-017 SHALL order values: differing signs -> negative smaller (-0 < +0); both positive -> smaller {expo,mant} smaller; both negative -> larger {expo,mant} smaller.
REQ-018 SHALL give NaN/Inf no special handling; bit-field ordering per REQ-017 applies.
REQ-019 SHALL on ties keep the incumbent, so out_idx_o reports the earliest minimum.
REQ-020 SHALL implement FSM states IDLE, ACCUM, HOLD.
REQ-021 SHALL in IDLE assert in_ready_o; accepted beat loads min=data, idx=0, count=1; go ACCUM, or HOLD if in_last_i.
REQ-022 SHALL in ACCUM assert in_ready_o; accepted beat updates min/idx if strictly smaller, position = current count, count+1; go HOLD if in_last_i.
REQ-023 SHALL in HOLD deassert in_ready_o, assert out_valid_o with stable outputs until output beat, then go IDLE.
REQ-024 SHALL assert out_valid_o exactly one cycle after last beat accepted (latency 1); no combinational in-to-out path.
REQ-025 SHALL hold outputs stable while out_valid_o & !out_ready_i.
REQ-026 SHALL wrap count modulo 2^IDX_WIDTH; out_count_o=0 denotes a full 2^IDX_WIDTH frame.
REQ-027 SHALL keep state while in_valid_i low in ACCUM (gaps allowed, no timeout).
REQ-028 SHALL ignore in_valid_i/in_data_i/in_last_i while in HOLD.

Reset
REQ-029 SHALL on rst_ni low go IDLE, out_valid_o=0, in_ready_o=1 after release, out_min_o=0, out_idx_o=0, out_count_o=0.
REQ-030 SHALL discard any partial frame or pending result when reset asserts mid-operation.

Structure
REQ-031 SHALL place FSM state enum and default width constants in shared package fp_reduce_pkg.
REQ-032 SHALL instantiate one combinational sub-module fp_less_than (a, b -> a_lt_b) implementing REQ-017.
REQ-033 SHALL register all outputs; in_ready_o derived from state only.

Verification
REQ-034 SHALL cover: frame 0x3F800000, 0xC0000000, 0x40400000(last) -> out_min 0xC0000000, idx 1, count 3, out_valid one cycle after last.
REQ-035 SHALL cover: 0x80000000, 0x00000000(last) -> min 0x80000000, idx 0; reversed order -> min 0x80000000, idx 1.
REQ-036 SHALL cover: ties 0x40000000 x3 (last on third) -> idx 0, count 3; single-beat frame 0x7F800000(last) -> min 0x7F800000, idx 0, count 1.
REQ-037 SHALL cover: out_ready_i low 5 cycles in HOLD with in_valid_i high -> in_ready_o 0, outputs stable, no beat consumed; next frame starts after release.
REQ-038 SHALL cover: rst_ni low after 2 beats of a frame -> out_valid_o 0; following frame 0xBF800000(last) -> min 0xBF800000, idx 0, count 1.

Source files
------------

// File: rtl/fp_reduce_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fp_reduce_pkg : shared FSM state encoding and default float field widths
// Revision      : 1.0
// ---------------------------------------------------------------------------
package fp_reduce_pkg;

  localparam int DEF_EXPO_WIDTH = 8;
  localparam int DEF_MANT_WIDTH = 23;
  localparam int DEF_DATA_WIDTH = 1 + DEF_EXPO_WIDTH + DEF_MANT_WIDTH;
  localparam int DEF_IDX_WIDTH  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/fp_less_than.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fp_less_than : combinational sign/magnitude ordering of two float bit fields
// Revision     : 1.0
// ---------------------------------------------------------------------------
module fp_less_than
  import fp_reduce_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int EXPO_WIDTH = DEF_EXPO_WIDTH,
  parameter int MANT_WIDTH = DEF_MANT_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  output logic                  a_lt_b
);

  localparam int MAG_WIDTH = EXPO_WIDTH + MANT_WIDTH;

  logic                 sign_a;
  logic                 sign_b;
  logic [MAG_WIDTH-1:0] mag_a;
  logic [MAG_WIDTH-1:0] mag_b;

  assign sign_a = a[DATA_WIDTH-1];
  assign sign_b = b[DATA_WIDTH-1];
  assign mag_a  = a[MAG_WIDTH-1:0];
  assign mag_b  = b[MAG_WIDTH-1:0];

  // NaN/Inf are ordered purely by their bit fields; -0 sorts below +0.
  always_comb begin
    a_lt_b = 1'b0;
    if (sign_a != sign_b)
      a_lt_b = sign_a;
    else if (!sign_a)
      a_lt_b = (mag_a < mag_b);
    else
      a_lt_b = (mag_a > mag_b);
  end

endmodule
`default_nettype wire

// File: rtl/fp_min_reduce.sv
`default_nettype none
// ---------------------------------------------------------------------------
// fp_min_reduce : streaming per-frame float minimum with index and count
// Revision      : 1.0
// ---------------------------------------------------------------------------
module fp_min_reduce
  import fp_reduce_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int EXPO_WIDTH = DEF_EXPO_WIDTH,
  parameter int MANT_WIDTH = DEF_MANT_WIDTH,
  parameter int IDX_WIDTH  = DEF_IDX_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_WIDTH-1:0] in_data_i,
  input  logic                  in_valid_i,
  input  logic                  in_last_i,
  output logic                  in_ready_o,
  output logic [DATA_WIDTH-1:0] out_min_o,
  output logic [IDX_WIDTH-1:0]  out_idx_o,
  output logic [IDX_WIDTH-1:0]  out_count_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i
);

  localparam logic [IDX_WIDTH-1:0] IDX_ONE = {{(IDX_WIDTH-1){1'b0}}, 1'b1};

  state_t                state;
  logic [DATA_WIDTH-1:0] min_q;
  logic [IDX_WIDTH-1:0]  idx_q;
  logic [IDX_WIDTH-1:0]  count_q;
  logic                  in_ready_q;
  logic                  out_valid_q;
  logic                  data_lt_min;
  logic                  in_fire;

  assign in_fire = in_valid_i & in_ready_q;

  fp_less_than #(
    .DATA_WIDTH (DATA_WIDTH),
    .EXPO_WIDTH (EXPO_WIDTH),
    .MANT_WIDTH (MANT_WIDTH)
  ) u_less_than (
    .a      (in_data_i),
    .b      (min_q),
    .a_lt_b (data_lt_min)
  );

  // in_ready/out_valid are registered alongside the state so they always
  // decode the state that is current, never the inputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      min_q       <= '0;
      idx_q       <= '0;
      count_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_fire) begin
            min_q   <= in_data_i;
            idx_q   <= '0;
            count_q <= IDX_ONE;
            if (in_last_i) begin
              state       <= HOLD;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          if (in_fire) begin
            // Strict compare keeps the incumbent on ties: earliest index wins.
            if (data_lt_min) begin
              min_q <= in_data_i;
              idx_q <= count_q;
            end
            count_q <= count_q + IDX_ONE;
            if (in_last_i) begin
              state       <= HOLD;
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end
          end
        end
        HOLD: begin
          if (out_ready_i) begin
            state       <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready_o  = in_ready_q;
  assign out_valid_o = out_valid_q;
  assign out_min_o   = min_q;
  assign out_idx_o   = idx_q;
  assign out_count_o = count_q;

endmodule
`default_nettype wire
